// File: rtl/grf_wb.sv
// 32 x DATA_W register file: two combinational read ports with optional write-first bypass, one write port.
// Writes land on the rising edge; the trace outputs lag by one cycle. There is no backpressure and WE is taken every cycle.
module grf_wb #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    input  logic [4:0]        A3,
    input  logic [DATA_W-1:0] WD,
    input  logic [31:0]       PC,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              wb_valid,
    output logic [31:0]       wb_pc,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_count
);

    // $0 is hard-wired to zero, so only $1..$31 have storage.
    logic [DATA_W-1:0] regs_q [1:31];

    logic              wb_valid_q;
    logic [31:0]       wb_pc_q;
    logic [4:0]        wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [31:0]       wb_count_q;
    logic [31:0]       wb_count_d;

    logic reg_wr;
    assign reg_wr = WE && (A3 != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_wr) begin
            regs_q[A3] <= WD;
        end
    end

    always_comb begin
        RD1 = '0;
        if (A1 != 5'd0) begin
            if (BYPASS && WE && (A3 == A1)) begin
                RD1 = WD;
            end else begin
                RD1 = regs_q[A1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (A2 != 5'd0) begin
            if (BYPASS && WE && (A3 == A2)) begin
                RD2 = WD;
            end else begin
                RD2 = regs_q[A2];
            end
        end
    end

    // Count every write request, including discarded $0 writes; wraps silently.
    assign wb_count_d = WE ? (wb_count_q + 32'd1) : wb_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_count_q <= '0;
        end else begin
            wb_valid_q <= WE;
            wb_count_q <= wb_count_d;
            if (WE) begin
                wb_pc_q   <= PC;
                wb_addr_q <= A3;
                wb_data_q <= WD;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_pc    = wb_pc_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_grf_wb.sv
// Bench for grf_wb: a bypassing and a non-bypassing instance share stimulus and are checked against an array model.
module tb_grf_wb;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD, PC;

    logic [31:0] rd1_b, rd2_b, wb_pc_b, wb_data_b, wb_count_b;
    logic        wb_valid_b;
    logic [4:0]  wb_addr_b;
    logic [31:0] rd1_n, rd2_n, wb_pc_n, wb_data_n, wb_count_n;
    logic        wb_valid_n;
    logic [4:0]  wb_addr_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural registers plus the last write request.
    logic [31:0] mregs [32];
    logic        m_valid;
    logic [31:0] m_pc, m_data, m_count;
    logic [4:0]  m_addr;

    grf_wb #(.DATA_W(32), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .PC(PC),
        .RD1(rd1_b), .RD2(rd2_b), .wb_valid(wb_valid_b), .wb_pc(wb_pc_b),
        .wb_addr(wb_addr_b), .wb_data(wb_data_b), .wb_count(wb_count_b)
    );

    grf_wb #(.DATA_W(32), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .PC(PC),
        .RD1(rd1_n), .RD2(rd2_n), .wb_valid(wb_valid_n), .wb_pc(wb_pc_n),
        .wb_addr(wb_addr_n), .wb_data(wb_data_n), .wb_count(wb_count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(WE)) else $error("FAIL we_known WE=%b", WE);
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && WE && (A3 == a)) return WD;
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_valid = 1'b0; m_pc = '0; m_addr = '0; m_data = '0; m_count = '0;
    endtask

    // One rising edge with reset low; the model retires the current inputs.
    task automatic clock_edge();
        @(posedge clk);
        if (WE && (A3 != 5'd0)) mregs[A3] = WD;
        m_valid = WE;
        if (WE) begin
            m_pc = PC; m_addr = A3; m_data = WD;
            m_count = m_count + 32'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        WE = 1'b0; A1 = 5'd5; A2 = 5'd31; A3 = 5'd0; WD = '0; PC = '0; reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (rd1_b !== 32'd0 || rd1_n !== 32'd0) begin n_fail++; $display("FAIL reset_rd1 got=%h/%h exp=0", rd1_b, rd1_n); end
        n_checks++; if (rd2_b !== 32'd0 || rd2_n !== 32'd0) begin n_fail++; $display("FAIL reset_rd2 got=%h/%h exp=0", rd2_b, rd2_n); end
        n_checks++; if (wb_valid_b !== 1'b0 || wb_valid_n !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b/%b exp=0", wb_valid_b, wb_valid_n); end
        n_checks++; if (wb_count_b !== 32'd0 || wb_count_n !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%h/%h exp=0", wb_count_b, wb_count_n); end
        n_checks++; if (wb_pc_b !== 32'd0 || wb_addr_b !== 5'd0 || wb_data_b !== 32'd0) begin n_fail++; $display("FAIL reset_trace got pc=%h addr=%h data=%h exp=0", wb_pc_b, wb_addr_b, wb_data_b); end
        model_reset();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_write_readback();
        WE = 1'b1; A3 = 5'd8; WD = 32'h12345678; PC = 32'h00003000;
        clock_edge();
        WE = 1'b0; A1 = 5'd8;
        #1;
        n_checks++; if (rd1_b !== 32'h12345678 || rd1_n !== 32'h12345678) begin n_fail++; $display("FAIL wr_rd1 got=%h/%h exp=12345678", rd1_b, rd1_n); end
        n_checks++; if (wb_valid_b !== 1'b1 || wb_pc_b !== 32'h00003000) begin n_fail++; $display("FAIL wr_trace_pc got v=%b pc=%h exp v=1 pc=00003000", wb_valid_b, wb_pc_b); end
        n_checks++; if (wb_addr_b !== 5'd8 || wb_data_b !== 32'h12345678) begin n_fail++; $display("FAIL wr_trace_data got a=%0d d=%h exp a=8 d=12345678", wb_addr_b, wb_data_b); end
        n_checks++; if (wb_count_b !== m_count || wb_count_n !== m_count) begin n_fail++; $display("FAIL wr_count got=%h/%h exp=%h", wb_count_b, wb_count_n, m_count); end
        clock_edge();
        n_checks++; if (wb_valid_b !== 1'b0 || wb_data_b !== 32'h12345678) begin n_fail++; $display("FAIL wr_trace_hold got v=%b d=%h exp v=0 d=12345678", wb_valid_b, wb_data_b); end
    endtask

    task automatic test_zero_reg();
        WE = 1'b1; A3 = 5'd0; A1 = 5'd0; WD = 32'hFFFFFFFF; PC = 32'h00003004;
        #1;
        n_checks++; if (rd1_b !== 32'd0 || rd1_n !== 32'd0) begin n_fail++; $display("FAIL zero_bypass got=%h/%h exp=0", rd1_b, rd1_n); end
        clock_edge();
        WE = 1'b0;
        #1;
        n_checks++; if (rd1_b !== 32'd0 || rd1_n !== 32'd0) begin n_fail++; $display("FAIL zero_read got=%h/%h exp=0", rd1_b, rd1_n); end
        n_checks++; if (wb_valid_b !== 1'b1 || wb_addr_b !== 5'd0 || wb_data_b !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL zero_trace got v=%b a=%0d d=%h exp v=1 a=0 d=ffffffff", wb_valid_b, wb_addr_b, wb_data_b); end
        n_checks++; if (wb_count_b !== m_count || wb_count_n !== m_count) begin n_fail++; $display("FAIL zero_count got=%h/%h exp=%h", wb_count_b, wb_count_n, m_count); end
    endtask

    task automatic test_bypass();
        WE = 1'b1; A3 = 5'd9; WD = 32'hA;
        clock_edge();
        WE = 1'b1; A3 = 5'd9; WD = 32'hB; A1 = 5'd9; A2 = 5'd9;
        #1;
        n_checks++; if (rd1_b !== 32'hB || rd2_b !== 32'hB) begin n_fail++; $display("FAIL byp_on got=%h/%h exp=b", rd1_b, rd2_b); end
        n_checks++; if (rd1_n !== 32'hA || rd2_n !== 32'hA) begin n_fail++; $display("FAIL byp_off got=%h/%h exp=a", rd1_n, rd2_n); end
        clock_edge();
        WE = 1'b0;
        #1;
        n_checks++; if (rd1_b !== 32'hB || rd2_b !== 32'hB || rd1_n !== 32'hB || rd2_n !== 32'hB) begin n_fail++; $display("FAIL byp_next got=%h/%h/%h/%h exp=b", rd1_b, rd2_b, rd1_n, rd2_n); end
    endtask

    task automatic test_reset_during_write();
        @(negedge clk);
        WE = 1'b1; A3 = 5'd3; WD = 32'h55; A1 = 5'd3;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        WE = 1'b0;
        #1;
        n_checks++; if (rd1_b !== 32'd0 || rd1_n !== 32'd0) begin n_fail++; $display("FAIL rstwr_reg got=%h/%h exp=0", rd1_b, rd1_n); end
        n_checks++; if (wb_count_b !== 32'd0 || wb_valid_b !== 1'b0) begin n_fail++; $display("FAIL rstwr_trace got cnt=%h v=%b exp cnt=0 v=0", wb_count_b, wb_valid_b); end
        @(negedge clk) reset = 1'b0;
        WE = 1'b1; A3 = 5'd3; WD = 32'h66;
        clock_edge();
        WE = 1'b0;
        #1;
        n_checks++; if (rd1_b !== 32'h66 || rd1_n !== 32'h66) begin n_fail++; $display("FAIL rstwr_after got=%h/%h exp=66", rd1_b, rd1_n); end
        n_checks++; if (wb_count_b !== 32'd1) begin n_fail++; $display("FAIL rstwr_count got=%h exp=1", wb_count_b); end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        WE = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        for (int i = 1; i < 32; i++) begin
            WE = 1'b1; A3 = 5'(i); WD = 32'h100 + 32'(i); PC = 32'h4000 + 32'(4 * i);
            clock_edge();
        end
        WE = 1'b0;
        for (int i = 1; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'($urandom_range(0, 31));
            #1;
            n_checks++; if (rd1_b !== 32'h100 + 32'(i) || rd1_n !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL sweep_rd1[%0d] got=%h/%h exp=%h", i, rd1_b, rd1_n, 32'h100 + 32'(i)); end
            n_checks++; if (rd2_b !== exp_rd(A2, 1'b1) || rd2_n !== exp_rd(A2, 1'b0)) begin n_fail++; $display("FAIL sweep_rd2[%0d] got=%h/%h exp=%h", A2, rd2_b, rd2_n, exp_rd(A2, 1'b0)); end
        end
        n_checks++; if (wb_count_b !== 32'd31 || wb_count_n !== 32'd31) begin n_fail++; $display("FAIL sweep_count got=%h/%h exp=31", wb_count_b, wb_count_n); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            WE = 1'($urandom_range(0, 1));
            A3 = 5'($urandom); WD = $urandom; PC = $urandom;
            A1 = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            A2 = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom);
            #1;
            n_checks++; if (rd1_b !== exp_rd(A1, 1'b1) || rd1_n !== exp_rd(A1, 1'b0)) begin n_fail++; $display("FAIL rnd_rd1 a=%0d got=%h/%h exp=%h/%h", A1, rd1_b, rd1_n, exp_rd(A1, 1'b1), exp_rd(A1, 1'b0)); end
            n_checks++; if (rd2_b !== exp_rd(A2, 1'b1) || rd2_n !== exp_rd(A2, 1'b0)) begin n_fail++; $display("FAIL rnd_rd2 a=%0d got=%h/%h exp=%h/%h", A2, rd2_b, rd2_n, exp_rd(A2, 1'b1), exp_rd(A2, 1'b0)); end
            clock_edge();
            n_checks++;
            if (wb_valid_b !== m_valid || wb_pc_b !== m_pc || wb_addr_b !== m_addr || wb_data_b !== m_data || wb_count_b !== m_count) begin
                n_fail++; $display("FAIL rnd_trace got v=%b pc=%h a=%0d d=%h c=%h exp v=%b pc=%h a=%0d d=%h c=%h",
                                   wb_valid_b, wb_pc_b, wb_addr_b, wb_data_b, wb_count_b, m_valid, m_pc, m_addr, m_data, m_count);
            end
        end
    endtask

    task automatic test_count_wrap();
        WE = 1'b0;
        force u_byp.wb_count_d = 32'hFFFFFFFF;
        clock_edge();
        release u_byp.wb_count_d;
        n_checks++; if (wb_count_b !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffffffff", wb_count_b); end
        WE = 1'b1; A3 = 5'd4; WD = 32'h77;
        clock_edge();
        WE = 1'b0;
        n_checks++; if (wb_count_b !== 32'd0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0", wb_count_b); end
        n_checks++; if (wb_count_n !== m_count) begin n_fail++; $display("FAIL wrap_other got=%h exp=%h", wb_count_n, m_count); end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_zero_reg();
        test_bypass();
        test_reset_during_write();
        test_sweep();
        test_random();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
